// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_W     = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    ERROR,
    DONE
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 30
);

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              imem_we;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_addr, imem_data, imem_we
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_addr, imem_data, imem_we
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte packer: keeps the three oldest bytes; the fourth completes o_word
// combinationally in the same cycle that o_word_full pulses.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte_in,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [23:0]           r_word;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_accept) begin
      r_word     <= {r_word[15:0], i_byte_in};
      r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
    end
  end

  assign o_word      = {r_word, i_byte_in};
  assign o_word_full = i_accept && (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a byte stream into words, writes them, then
// releases the CPU. Define IMEM_LOADER_CHECKSUM_EN to require an XOR-of-words trailer.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 30,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       LEN_W     = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  imem_loader_if.slave     io_bus,
  output logic             o_cpu_reset,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e TAIL_ST = CHECK;
`else
  localparam state_e TAIL_ST = DONE;
`endif

  state_e            r_state, w_state_next;
  logic [LEN_W-1:0]  r_left;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_data;
  logic              w_accept;
  logic              w_start;
  logic              w_word_full;
  logic [31:0]       w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       r_xor;
`endif

  assign w_accept = io_bus.byte_valid && io_bus.byte_ready;
  assign w_start  = (r_state == IDLE) && i_start;

  word_assembler u_word_assembler (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (w_start),
    .i_accept    (w_accept),
    .i_byte_in   (io_bus.byte_in),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (i_start) w_state_next = (i_len != '0) ? LOAD : TAIL_ST;
      LOAD:  if (w_word_full) w_state_next = WRITE;
      WRITE: w_state_next = (r_left == LEN_W'(1)) ? TAIL_ST : LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (w_word_full) w_state_next = (w_word == r_xor) ? DONE : ERROR;
`endif
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_left    <= '0;
      r_addr    <= BASE_ADDR;
      r_wr_addr <= BASE_ADDR;
      r_data    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor     <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_left <= i_len;
        r_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_xor  <= '0;
`endif
      end
      // Capture at the completing byte so the write port only moves when a new word exists.
      if ((r_state == LOAD) && w_word_full) begin
        r_data    <= w_word;
        r_wr_addr <= r_addr;
      end
      if (r_state == WRITE) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_left <= r_left - LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_xor  <= r_xor ^ r_data;
`endif
      end
    end
  end

  assign io_bus.byte_ready = (r_state == LOAD) || (r_state == CHECK);
  assign io_bus.imem_we    = (r_state == WRITE);
  assign io_bus.imem_addr  = r_wr_addr;
  assign io_bus.imem_data  = r_data;

  assign o_busy      = (r_state == LOAD) || (r_state == WRITE) || (r_state == CHECK);
  assign o_done      = (r_state == DONE);
  assign o_cpu_reset = (r_state != DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign o_err       = (r_state == ERROR);
`else
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and top-of-space) run the same stream in lockstep
// and their writes are compared with a word-list model; IMEM_LOADER_CHECKSUM_EN adds trailer cases.
module tb_imem_loader;

  localparam logic [29:0] BASE1 = 30'h3FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        cpu_reset0, busy0, done0, err0;
  logic        cpu_reset1, busy1, done1, err1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [61:0] wq0[$];
  logic [61:0] wq1[$];
  logic [31:0] words[$];
  logic [7:0]  stream[$];
  logic [31:0] trailer;
  logic [61:0] last0 = '0;
  logic        prev_live = 1'b0;
  logic        done_seen = 1'b0;
  int          hold_viol = 0;
  int          last_we_cyc = 0;
  int          done_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader_if #(.ADDR_W(30)) if0 ();
  imem_loader_if #(.ADDR_W(30)) if1 ();

  assign if0.byte_in    = byte_in;
  assign if0.byte_valid = byte_valid;
  assign if1.byte_in    = byte_in;
  assign if1.byte_valid = byte_valid;

  imem_loader #(.ADDR_W(30), .BASE_ADDR(30'h0), .LEN_W(16)) dut0 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_len       (len),
    .io_bus      (if0),
    .o_cpu_reset (cpu_reset0),
    .o_busy      (busy0),
    .o_done      (done0),
    .o_err       (err0)
  );

  imem_loader #(.ADDR_W(30), .BASE_ADDR(BASE1), .LEN_W(16)) dut1 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_len       (len),
    .io_bus      (if1),
    .o_cpu_reset (cpu_reset1),
    .o_busy      (busy1),
    .o_done      (done1),
    .o_err       (err1)
  );

  always @(negedge clk) begin
    if (if0.imem_we) begin
      wq0.push_back({if0.imem_addr, if0.imem_data});
      last_we_cyc <= cyc;
    end
    if (if1.imem_we) wq1.push_back({if1.imem_addr, if1.imem_data});
    if (rst) done_seen <= 1'b0;
    else if (done0 && !done_seen) begin
      done_seen <= 1'b1;
      done_cyc  <= cyc;
    end
    if (!rst && prev_live && !if0.imem_we && ({if0.imem_addr, if0.imem_data} != last0))
      hold_viol <= hold_viol + 1;
    last0     <= {if0.imem_addr, if0.imem_data};
    prev_live <= !rst;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = '0; len = '0;
    repeat (3) @(negedge clk);
    wq0.delete();
    wq1.delete();
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // vmode 0: valid always high; 1: valid pattern 1/0/0; 2: random valid.
  task automatic send_bytes(input int vmode, input string tag);
    int idx = 0;
    int c   = 0;
    logic v, fire;
    while (idx < stream.size() && c < 3000) begin
      @(negedge clk);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (c % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_in    = v ? stream[idx] : 8'($urandom);
      fire       = v && if0.byte_ready;
      @(posedge clk);
      if (fire) idx++;
      c++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (idx != stream.size()) check({tag, " stream timeout"}, 64'(idx), 64'(stream.size()));
  endtask

  task automatic wait_end(input string tag);
    int c = 0;
    while (!(done0 || err0) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!(done0 || err0)) check({tag, " end timeout"}, 64'(done0 | err0), 64'd1);
  endtask

  task automatic run_load(input int vmode, input string tag);
    logic [31:0] x = '0;
    logic        exp_err = 1'b0;
    logic [29:0] a1;
    stream.delete();
    foreach (words[k]) begin
      x ^= words[k];
      for (int b = 3; b >= 0; b--) stream.push_back(words[k][8*b +: 8]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int b = 3; b >= 0; b--) stream.push_back(trailer[8*b +: 8]);
    exp_err = (trailer != x);
`endif
    do_start(16'(words.size()));
    send_bytes(vmode, tag);
    wait_end(tag);
    @(negedge clk);
    check({tag, " count0"}, 64'(wq0.size()), 64'(words.size()));
    check({tag, " count1"}, 64'(wq1.size()), 64'(words.size()));
    foreach (words[k]) begin
      a1 = BASE1 + 30'(k);
      check({tag, " write0"}, (k < wq0.size()) ? 64'(wq0[k]) : 64'hx, 64'({30'(k), words[k]}));
      check({tag, " write1"}, (k < wq1.size()) ? 64'(wq1[k]) : 64'hx, 64'({a1, words[k]}));
    end
    check({tag, " done"}, 64'(done0), 64'(!exp_err));
    check({tag, " err"}, 64'(err0), 64'(exp_err));
    check({tag, " cpu_reset"}, 64'(cpu_reset0), 64'(exp_err));
    check({tag, " busy"}, 64'(busy0), 64'd0);
    check({tag, " done1"}, 64'(done1), 64'(!exp_err));
  endtask

  task automatic set_xor_trailer();
    trailer = '0;
    foreach (words[k]) trailer ^= words[k];
  endtask

  initial begin
    int prev;

    // Reset state
    do_reset();
    check("rst cpu_reset", 64'(cpu_reset0), 64'd1);
    check("rst imem_we", 64'(if0.imem_we), 64'd0);
    check("rst byte_ready", 64'(if0.byte_ready), 64'd0);
    check("rst done", 64'(done0), 64'd0);
    check("rst busy", 64'(busy0), 64'd0);
    check("rst err", 64'(err0), 64'd0);
    check("rst addr0", 64'(if0.imem_addr), 64'd0);
    check("rst addr1", 64'(if1.imem_addr), 64'(BASE1));
    check("rst data", 64'(if0.imem_data), 64'd0);

    // Directed two-word image, valid always high; dut1 covers the address wrap
    words = '{32'h8C01_0004, 32'h0022_1820};
    set_xor_trailer();
    run_load(0, "basic");
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("basic done latency", 64'(done_cyc - last_we_cyc), 64'd1);
`endif

    // DONE ignores start and byte_valid
    prev = wq0.size();
    @(negedge clk);
    start = 1'b1; len = 16'd3; byte_valid = 1'b1; byte_in = 8'h55;
    repeat (6) @(negedge clk);
    start = 1'b0; byte_valid = 1'b0;
    check("done sticky", 64'(done0), 64'd1);
    check("done no write", 64'(wq0.size()), 64'(prev));
    check("done ready", 64'(if0.byte_ready), 64'd0);

    // Same image with valid toggling 1/0/0
    do_reset();
    run_load(1, "toggle");

    // Zero-length load
    do_reset();
    do_start(16'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("len0 busy check", 64'(busy0), 64'd1);
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(0, "len0");
    wait_end("len0");
`endif
    check("len0 done", 64'(done0), 64'd1);
    check("len0 cpu_reset", 64'(cpu_reset0), 64'd0);
    @(negedge clk);
    check("len0 no write", 64'(wq0.size()), 64'd0);

    // Reset mid-word discards the partial word
    do_reset();
    do_start(16'd1);
    stream = '{8'hAA, 8'hBB};
    send_bytes(0, "abort");
    check("abort busy", 64'(busy0), 64'd1);
    check("abort cpu_reset", 64'(cpu_reset0), 64'd1);
    check("abort no write", 64'(wq0.size()), 64'd0);
    do_reset();
    check("abort rst ready", 64'(if0.byte_ready), 64'd0);
    words = '{32'h1234_5678};
    set_xor_trailer();
    run_load(0, "reload");

    // Random images with random valid gaps
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 6);
      do_reset();
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
      set_xor_trailer();
      run_load(2, "random");
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    words = '{32'h0000_0001, 32'h0000_0002};
    trailer = 32'h0000_0003;
    run_load(0, "cksum good");
    do_reset();
    trailer = 32'h0000_0004;
    run_load(0, "cksum bad");
    repeat (3) @(negedge clk);
    check("cksum bad sticky err", 64'(err0), 64'd1);
    check("cksum bad sticky cpu_reset", 64'(cpu_reset0), 64'd1);
`endif

    check("addr/data hold", 64'(hold_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
